// File: rtl/mp_add_seq_pkg.sv
// -----------------------------------------------------------------------------
// mp_add_seq_pkg
// Shared types and helpers for the multi-precision add sequencer.
//   state_t   : controller states (IDLE, RUN, DONE)
//   idx_width : width of the word index counter, $clog2(words) with a floor of 1
// -----------------------------------------------------------------------------
package mp_add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-word operand still needs a 1-bit index register.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/carry_bypass_adder.sv
// -----------------------------------------------------------------------------
// carry_bypass_adder
// WIDTH-bit adder split into BLOCK_SIZE-bit ripple blocks. When every bit of a
// block propagates, the block carry-in is forwarded straight to the next block.
// Ports:
//   a, b  in  WIDTH  addends
//   cin   in  1      carry into bit 0
//   sum   out WIDTH  a + b + cin (mod 2^WIDTH)
//   cout  out 1      carry out of the top bit
// -----------------------------------------------------------------------------
module carry_bypass_adder #(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = WIDTH / BLOCK_SIZE;

    if ((BLOCK_SIZE < 1) || (WIDTH % BLOCK_SIZE != 0)) begin : g_bad_block
        $error("carry_bypass_adder: WIDTH must be a multiple of BLOCK_SIZE");
    end

    logic [WIDTH-1:0] s;
    logic             c;
    logic             c_blk_in;
    logic             p_all;
    logic             p;

    // NOTE: every variable written here gets a value before any branch,
    // otherwise the combinational block would infer a latch.
    always_comb begin
        s        = '0;
        c        = cin;
        c_blk_in = 1'b0;
        p_all    = 1'b1;
        p        = 1'b0;
        for (int blk = 0; blk < NBLK; blk++) begin
            c_blk_in = c;
            p_all    = 1'b1;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                p                     = a[blk*BLOCK_SIZE+i] ^ b[blk*BLOCK_SIZE+i];
                s[blk*BLOCK_SIZE+i]   = p ^ c;
                c                     = (a[blk*BLOCK_SIZE+i] & b[blk*BLOCK_SIZE+i]) | (p & c);
                p_all                 = p_all & p;
            end
            // Bypass path: a fully propagating block passes its carry-in through.
            if (p_all) begin
                c = c_blk_in;
            end
        end
    end

    assign sum  = s;
    assign cout = c;

endmodule

// File: rtl/mp_add_sequencer.sv
// -----------------------------------------------------------------------------
// mp_add_sequencer
// Adds two WORDS*WIDTH-bit operands through one shared carry_bypass_adder,
// one word per cycle, least significant word first, with the carry registered
// between words. valid/ready handshake on both sides.
//
// Optional feature (macro MP_ADD_SEQ_SUB_EN): adds input port `sub`; when set
// at acceptance, B words are inverted and the initial carry forced to 1, giving
// A - B with cout=1 meaning no borrow.
//
// Ports:
//   clk        in  1            rising-edge clock
//   rst_n      in  1            synchronous active-low reset
//   in_valid   in  1            operands presented
//   in_ready   out 1            high in IDLE only
//   a, b       in  WORDS*WIDTH  operands
//   cin        in  1            carry into word 0
//   sub        in  1            subtract select (MP_ADD_SEQ_SUB_EN only)
//   out_valid  out 1            result available (registered)
//   out_ready  in  1            consumer accepts result
//   sum        out WORDS*WIDTH  result (registered)
//   cout       out 1            carry out of the top word (registered)
//   busy       out 1            high in RUN or DONE
// -----------------------------------------------------------------------------
module mp_add_sequencer
    import mp_add_seq_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 4,
    parameter int WORDS      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORDS*WIDTH-1:0] a,
    input  logic [WORDS*WIDTH-1:0] b,
    input  logic                   cin,
`ifdef MP_ADD_SEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDS*WIDTH-1:0] sum,
    output logic                   cout,
    output logic                   busy
);

    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    if (WORDS < 1) begin : g_bad_words
        $error("mp_add_sequencer: WORDS must be at least 1");
    end

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       idx;
    logic                   carry;
    logic [WORDS*WIDTH-1:0] a_reg;
    logic [WORDS*WIDTH-1:0] b_reg;
    logic [WORDS*WIDTH-1:0] sum_reg;
    logic                   cout_reg;
    logic                   out_valid_reg;
`ifdef MP_ADD_SEQ_SUB_EN
    logic                   sub_reg;
`endif

    logic             accept;
    logic             last_word;
    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             first_carry;

    assign accept    = (state == IDLE) && in_valid;
    assign last_word = (idx == LAST_IDX);

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_word) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state == RUN) || (state == DONE);
    end

    // ----------------------------------------------------------- datapath
    assign a_word = a_reg[idx*WIDTH +: WIDTH];

`ifdef MP_ADD_SEQ_SUB_EN
    // Subtraction is A + ~B + 1: invert B per word, force the initial carry.
    assign b_word      = sub_reg ? ~b_reg[idx*WIDTH +: WIDTH] : b_reg[idx*WIDTH +: WIDTH];
    assign first_carry = sub ? 1'b1 : cin;
`else
    assign b_word      = b_reg[idx*WIDTH +: WIDTH];
    assign first_carry = cin;
`endif

    carry_bypass_adder #(
        .WIDTH      (WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_adder (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: operand and result registers are ordinary flops, not a RAM, so
    // they are cleared in reset along with the control state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx           <= '0;
            carry         <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
            sub_reg       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= a;
                        b_reg <= b;
                        idx   <= '0;
                        carry <= first_carry;
`ifdef MP_ADD_SEQ_SUB_EN
                        sub_reg <= sub;
`endif
                    end
                end
                RUN: begin
                    // Words not yet reached keep their previous contents.
                    sum_reg[idx*WIDTH +: WIDTH] <= add_sum;
                    carry                       <= add_cout;
                    idx                         <= idx + IDX_W'(1);
                    if (last_word) begin
                        cout_reg      <= add_cout;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mp_add_sequencer
// Self-checking bench for mp_add_sequencer (WIDTH=16, BLOCK_SIZE=4, WORDS=4).
// Expected results come from whole-operand arithmetic on 65-bit values.
// Subtract cases are exercised only when MP_ADD_SEQ_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_mp_add_sequencer;

    localparam int WIDTH      = 16;
    localparam int BLOCK_SIZE = 4;
    localparam int WORDS      = 4;
    localparam int N          = WORDS * WIDTH;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mp_add_sequencer #(
        .WIDTH      (WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .WORDS      (WORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef MP_ADD_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {cout, sum} of the whole operation as one wide arithmetic result.
    function automatic logic [N:0] ref_result(input logic [N-1:0] av, input logic [N-1:0] bv,
                                              input logic ci, input logic sv);
        if (sv) return {1'b0, av} - {1'b0, bv} + {1'b1, {N{1'b0}}};
        return {1'b0, av} + {1'b0, bv} + {{N{1'b0}}, ci};
    endfunction

    // Present one operation, check latency, result, backpressure and release.
    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic ci,
                          input logic sv, input int hold, input string tag);
        logic [N:0] exp;
        int         lat;
        exp = ref_result(av, bv, ci, sv);
        check({tag, "_idle_ready"}, in_ready, 1);
        a = av; b = bv; cin = ci; sub = sv; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble the inputs to show the captured operands are used.
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom); sub = 1'($urandom);
        check({tag, "_run_busy"}, {busy, in_ready, out_valid}, 3'b100);
        lat = 0;
        while (!out_valid && lat <= 20) begin
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        check({tag, "_latency"}, lat, WORDS);
        check({tag, "_sum"}, sum, exp[N-1:0]);
        check({tag, "_cout"}, cout, exp[N]);
        check({tag, "_done_flags"}, {busy, in_ready}, 2'b10);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            @(posedge clk); #1;
            check({tag, "_hold"}, {out_valid, in_ready, cout, sum}, {2'b10, exp});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_release"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '1; b = '1; cin = 1'b1; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {in_ready, out_valid, busy, cout, sum}, {3'b100, 1'b0, {N{1'b0}}});
        rst_n = 1'b1;

        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, "cross_word");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1, "full_ripple");
        run_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 0, "complement");
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 5, "backpressure");

        // Reset two cycles after acceptance abandons the operation.
        a = 64'h0000_FFFF_0000_FFFF; b = 64'h1; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("reset_mid_run", {out_valid, cout, sum, in_ready, busy}, {1'b0, 1'b0, {N{1'b0}}, 2'b10});
        rst_n = 1'b1;
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 0, "after_reset");

`ifdef MP_ADD_SEQ_SUB_EN
        run_op(64'h1, 64'h2, 1'b0, 1'b1, 0, "sub_borrow");
        run_op(64'h2, 64'h1, 1'b1, 1'b1, 0, "sub_noborrow");
`endif

        for (int t = 0; t < 20; t++) begin
            logic sv_r;
            sv_r = 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
            sv_r = 1'($urandom);
`endif
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), sv_r,
                   int'($urandom_range(0, 3)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
